spi_ram_ctrl: RTL and testbench

//  Command-decoding single-port RAM controller sitting directly downstream of the SPI slave.
//  - Consumes the 10-bit rx_data/rx_valid words the slave produces.
//  - Maintains independent write and read address pointers.
//  - Returns read bytes on tx_data/tx_valid for the slave to shift out on MISO.

---
 rtl/shared_pkg.sv | 22 ++
 rtl/spi_ram_array.sv | 27 ++
 rtl/spi_ram_ctrl.sv | 83 ++++++++
 tb/tb_spi_ram_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared command encoding, sub-FSM states and sizing defaults for the SPI RAM controller.
package shared_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } ram_cmd_e;

    typedef enum logic {W_IDLE = 1'b0, W_ARMED = 1'b1} wr_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_ARMED = 1'b1} rd_state_e;

    localparam int MEM_DEPTH_DEF = 256;
    localparam int ADDR_SIZE_DEF = 8;

    // Out-of-range payload addresses fold back into the array rather than erroring.
    function automatic int unsigned wrap_addr(input logic [7:0] payload, input int unsigned depth);
        return int'(payload) % depth;
    endfunction

endpackage

// File: rtl/spi_ram_array.sv
// Single-port synchronous byte RAM; storage is never reset, only the read register is.
module spi_ram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end

    // dout only moves on a real read so it can serve directly as the held tx byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  dout <= '0;
        else if (re) dout <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI slave words into RAM address/data commands with separate
// write and read pointers; read bytes come back on tx_data one cycle later.
module spi_ram_ctrl
    import shared_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       cmd_err
);

    ram_cmd_e              cmd;
    wr_state_e             wr_st;
    rd_state_e             rd_st;
    logic [ADDR_SIZE-1:0]  wr_ptr;
    logic [ADDR_SIZE-1:0]  rd_ptr;
    logic [ADDR_SIZE-1:0]  payload_addr;
    logic                  do_wr;
    logic                  do_rd;
    logic                  seq_err;

    assign cmd          = ram_cmd_e'(rx_data[9:8]);
    assign payload_addr = ADDR_SIZE'(wrap_addr(rx_data[7:0], MEM_DEPTH));

    // rst_n gating drops a write whose edge lands while reset is held.
    assign do_wr   = rst_n && rx_valid && (cmd == WR_DATA) && (wr_st == W_ARMED);
    assign do_rd   = rx_valid && (cmd == RD_DATA) && (rd_st == R_ARMED);
    assign seq_err = rx_valid && (((cmd == WR_DATA) && (wr_st == W_IDLE)) ||
                                  ((cmd == RD_DATA) && (rd_st == R_IDLE)));

    function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
        if (!AUTO_INC)                          return p;
        else if (p == ADDR_SIZE'(MEM_DEPTH-1))  return '0;
        else                                    return p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_st    <= W_IDLE;
            rd_st    <= R_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            tx_valid <= do_rd;
            cmd_err  <= seq_err;
            if (rx_valid) begin
                case (cmd)
                    WR_ADDR: begin
                        wr_ptr <= payload_addr;
                        wr_st  <= W_ARMED;
                    end
                    WR_DATA: if (wr_st == W_ARMED) wr_ptr <= next_ptr(wr_ptr);
                    RD_ADDR: begin
                        rd_ptr <= payload_addr;
                        rd_st  <= R_ARMED;
                    end
                    RD_DATA: if (rd_st == R_ARMED) rd_ptr <= next_ptr(rd_ptr);
                    default: ;
                endcase
            end
        end
    end

    spi_ram_array #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE)) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (do_wr),
        .re   (do_rd),
        .addr (do_wr ? wr_ptr : rd_ptr),
        .din  (rx_data[7:0]),
        .dout (tx_data)
    );

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench: stimulus pushes expected tx/err events, a negedge monitor pops and compares.
module tb_spi_ram_ctrl;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] rx_data1 = '0, rx_data0 = '0;
    logic       rx_valid1 = 1'b0, rx_valid0 = 1'b0;
    logic [7:0] td1, td0;
    logic       tv1, tv0, ce1, ce0;

    exp_t q1[$];
    exp_t q0[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .tx_data(td1), .tx_valid(tv1), .cmd_err(ce1)
    );

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .tx_data(td0), .tx_valid(tv0), .cmd_err(ce0)
    );

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (tv1 || ce1) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL inc_unexpected: tx_valid=%0b cmd_err=%0b tx_data=%02h, required no event", tv1, ce1, td1);
                end else begin
                    e = q1.pop_front();
                    if (tv1 == e.err || ce1 != e.err || td1 !== e.data) begin
                        bad++;
                        $display("FAIL inc_event: got tx_valid=%0b cmd_err=%0b tx_data=%02h, required err=%0b tx_data=%02h",
                                 tv1, ce1, td1, e.err, e.data);
                    end
                end
            end
            if (tv0 || ce0) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL hold_unexpected: tx_valid=%0b cmd_err=%0b tx_data=%02h, required no event", tv0, ce0, td0);
                end else begin
                    e = q0.pop_front();
                    if (tv0 == e.err || ce0 != e.err || td0 !== e.data) begin
                        bad++;
                        $display("FAIL hold_event: got tx_valid=%0b cmd_err=%0b tx_data=%02h, required err=%0b tx_data=%02h",
                                 tv0, ce0, td0, e.err, e.data);
                    end
                end
            end
        end
    end

    // Drives one command for one cycle; an expected event is queued when exp_out is set.
    task automatic issue(input bit hold_dut, input logic [9:0] w,
                         input bit exp_out, input bit exp_err, input logic [7:0] exp_d);
        exp_t e;
        e.err  = exp_err;
        e.data = exp_d;
        if (hold_dut) begin
            rx_data0 = w; rx_valid0 = 1'b1;
            if (exp_out) q0.push_back(e);
        end else begin
            rx_data1 = w; rx_valid1 = 1'b1;
            if (exp_out) q1.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        rx_valid1 = 1'b0;
        rx_valid0 = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %02h, required %02h", name, got, req);
        end
    endtask

    initial begin
        #12;
        check("reset_tx_data", td1, 8'h00);
        check("reset_tx_valid", {7'd0, tv1}, 8'h00);
        check("reset_cmd_err", {7'd0, ce1}, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Sequencing errors straight out of reset
        issue(0, 10'h300, 1, 1, 8'h00);
        issue(0, 10'h155, 1, 1, 8'h00);
        idle(2);

        // Basic write then read
        issue(0, 10'h012, 0, 0, 8'h00);
        issue(0, 10'h1A5, 0, 0, 8'h00);
        issue(0, 10'h212, 0, 0, 8'h00);
        issue(0, 10'h300, 1, 0, 8'hA5);
        idle(2);

        // Pointer wrap 0xFF -> 0x00
        issue(0, 10'h0FF, 0, 0, 8'h00);
        issue(0, 10'h111, 0, 0, 8'h00);
        issue(0, 10'h122, 0, 0, 8'h00);
        issue(0, 10'h2FF, 0, 0, 8'h00);
        issue(0, 10'h300, 1, 0, 8'h11);
        issue(0, 10'h300, 1, 0, 8'h22);
        idle(2);

        // Reset asserted mid-burst while tx_valid is high
        issue(0, 10'h212, 0, 0, 8'h00);
        issue(0, 10'h300, 1, 0, 8'hA5);
        rx_data1 = 10'h300; rx_valid1 = 1'b1;
        #5;
        rst_n = 1'b0;
        #1;
        check("midreset_tx_data", td1, 8'h00);
        check("midreset_tx_valid", {7'd0, tv1}, 8'h00);
        check("midreset_cmd_err", {7'd0, ce1}, 8'h00);
        rx_valid1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Both FSMs back to idle; RAM keeps its contents across reset
        issue(0, 10'h300, 1, 1, 8'h00);
        issue(0, 10'h155, 1, 1, 8'h00);
        issue(0, 10'h200, 0, 0, 8'h00);
        issue(0, 10'h300, 1, 0, 8'h22);
        idle(2);

        // Write then read of the same location in the next cycle
        issue(0, 10'h230, 0, 0, 8'h00);
        issue(0, 10'h030, 0, 0, 8'h00);
        issue(0, 10'h177, 0, 0, 8'h00);
        issue(0, 10'h300, 1, 0, 8'h77);
        idle(1);

        // Held rx_valid bursts on write and read
        issue(0, 10'h040, 0, 0, 8'h00);
        issue(0, 10'h1C1, 0, 0, 8'h00);
        issue(0, 10'h1C2, 0, 0, 8'h00);
        issue(0, 10'h1C3, 0, 0, 8'h00);
        issue(0, 10'h240, 0, 0, 8'h00);
        issue(0, 10'h300, 1, 0, 8'hC1);
        issue(0, 10'h300, 1, 0, 8'hC2);
        issue(0, 10'h300, 1, 0, 8'hC3);
        idle(2);

        // Pointer held when auto-increment is off
        issue(1, 10'h005, 0, 0, 8'h00);
        issue(1, 10'h1AA, 0, 0, 8'h00);
        issue(1, 10'h1BB, 0, 0, 8'h00);
        issue(1, 10'h205, 0, 0, 8'h00);
        issue(1, 10'h300, 1, 0, 8'hBB);
        issue(1, 10'h300, 1, 0, 8'hBB);
        idle(4);

        check("inc_pending_left", 8'(q1.size()), 8'h00);
        check("hold_pending_left", 8'(q0.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
